// File: rtl/cpu_types_pkg.sv
// Shared dcache types for the snoop responder: address layout, frame block and FSM states.
package cpu_types_pkg;

  localparam int DTAG_W = 26;
  localparam int DIDX_W = 3;
  localparam int DBLK_W = 1;
  localparam int DBYT_W = 2;
  localparam int DSETS  = 1 << DIDX_W;

  typedef struct packed {
    logic [DTAG_W-1:0] tag;
    logic [DIDX_W-1:0] idx;
    logic [DBLK_W-1:0] blkoff;
    logic [DBYT_W-1:0] bytoff;
  } dcachef_t;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [DTAG_W-1:0] tag;
    logic [31:0]       upper;
    logic [31:0]       lower;
  } dcache_block;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    WORD0  = 3'd2,
    WORD1  = 3'd3,
    UPDATE = 3'd4,
    ACK    = 3'd5
  } snoop_state_t;

  function automatic logic tag_hit(input dcache_block blk, input logic [DTAG_W-1:0] tag);
    return blk.valid && (blk.tag == tag);
  endfunction

endpackage

// File: rtl/dsnoop_tag_match.sv
// Two-way tag compare and hit select for one set; way 0 wins when both ways match.
module dsnoop_tag_match
  import cpu_types_pkg::*;
(
  input  dcache_block       blk0,
  input  dcache_block       blk1,
  input  logic [DTAG_W-1:0] tag,
  output logic              hit,
  output logic              way,
  output logic              dirty,
  output logic [31:0]       lower,
  output logic [31:0]       upper
);

  logic m0;
  logic m1;

  always_comb begin
    m0    = tag_hit(blk0, tag);
    m1    = tag_hit(blk1, tag);
    hit   = m0 | m1;
    way   = ~m0 & m1;
    dirty = m0 ? blk0.dirty : (m1 & blk1.dirty);
    lower = m0 ? blk0.lower : blk1.lower;
    upper = m0 ? blk0.upper : blk1.upper;
  end

endmodule

// File: rtl/dcache_snoop_responder.sv
// Dcache snoop responder: looks up a snooped block, supplies dirty data, updates frame state.
// Optional LL/SC reservation clearing on invalidating snoops: define DCACHE_SNOOP_LR_EN.
module dcache_snoop_responder
  import cpu_types_pkg::*;
#(
  parameter int DWAYS = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    snoop_req,
  input  logic [31:0]             snoop_addr,
  input  logic                    snoop_inv,
  input  logic                    snoop_dready,
  input  logic                    cache_busy,
  input  dcache_block [DSETS-1:0] way_0,
  input  dcache_block [DSETS-1:0] way_1,
  input  logic [31:0]             link_register,
  input  logic                    valid_lr,
  output logic                    snoop_hit,
  output logic                    snoop_dirty,
  output logic [31:0]             snoop_data,
  output logic                    snoop_dvalid,
  output logic                    snoop_ack,
  output logic                    upd_en,
  output logic                    upd_way,
  output logic [DIDX_W-1:0]       upd_idx,
  output logic                    upd_valid,
  output logic                    upd_dirty,
  output logic                    lr_clear,
  output snoop_state_t            dbg_state
);

  // Handshake: snoop_req stays high until the one-cycle snoop_ack; a data word
  // is transferred on a cycle where snoop_dvalid and snoop_dready are both high,
  // and the word is held unchanged while snoop_dready is low.

  snoop_state_t state_q, state_d;
  dcachef_t     addr_q, addr_d;
  logic         inv_q, inv_d;
  logic         hit_q, hit_d;
  logic         dirty_q, dirty_d;
  logic         way_q, way_d;
  logic [31:0]  lo_q, lo_d;
  logic [31:0]  hi_q, hi_d;

  logic         tm_hit;
  logic         tm_way;
  logic         tm_dirty;
  logic [31:0]  tm_lower;
  logic [31:0]  tm_upper;

  dsnoop_tag_match u_tag_match (
    .blk0  (way_0[addr_q.idx]),
    .blk1  (way_1[addr_q.idx]),
    .tag   (addr_q.tag),
    .hit   (tm_hit),
    .way   (tm_way),
    .dirty (tm_dirty),
    .lower (tm_lower),
    .upper (tm_upper)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    inv_d        = inv_q;
    hit_d        = hit_q;
    dirty_d      = dirty_q;
    way_d        = way_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    snoop_hit    = 1'b0;
    snoop_dirty  = 1'b0;
    snoop_data   = '0;
    snoop_dvalid = 1'b0;
    snoop_ack    = 1'b0;
    upd_en       = 1'b0;
    upd_way      = 1'b0;
    upd_idx      = '0;
    upd_valid    = 1'b0;
    upd_dirty    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // cache_busy only gates the start; an active snoop runs to completion.
        if (snoop_req && !cache_busy) begin
          state_d = LOOKUP;
          addr_d  = dcachef_t'(snoop_addr);
          inv_d   = snoop_inv;
        end
      end
      LOOKUP: begin
        snoop_hit   = tm_hit;
        snoop_dirty = tm_dirty;
        hit_d       = tm_hit;
        dirty_d     = tm_dirty;
        way_d       = tm_way;
        lo_d        = tm_lower;
        hi_d        = tm_upper;
        if (!tm_hit) begin
          state_d = ACK;
        end else if (tm_dirty) begin
          state_d = WORD0;
        end else begin
          state_d = UPDATE;
        end
      end
      WORD0: begin
        snoop_hit    = hit_q;
        snoop_dirty  = dirty_q;
        snoop_data   = lo_q;
        snoop_dvalid = 1'b1;
        if (snoop_dready) begin
          state_d = WORD1;
        end
      end
      WORD1: begin
        snoop_hit    = hit_q;
        snoop_dirty  = dirty_q;
        snoop_data   = hi_q;
        snoop_dvalid = 1'b1;
        if (snoop_dready) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        snoop_hit   = hit_q;
        snoop_dirty = dirty_q;
        upd_en      = 1'b1;
        upd_way     = way_q;
        upd_idx     = addr_q.idx;
        upd_valid   = ~inv_q;
        state_d     = ACK;
      end
      ACK: begin
        snoop_hit   = hit_q;
        snoop_dirty = dirty_q;
        snoop_ack   = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      inv_q   <= 1'b0;
      hit_q   <= 1'b0;
      dirty_q <= 1'b0;
      way_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      inv_q   <= inv_d;
      hit_q   <= hit_d;
      dirty_q <= dirty_d;
      way_q   <= way_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  // ACK is visited exactly once per snoop on both hit and miss paths, so the pulse is single.
  logic sig_unused;
`ifdef DCACHE_SNOOP_LR_EN
  assign lr_clear   = (state_q == ACK) && inv_q && valid_lr &&
                      (link_register[31:3] == addr_q[31:3]);
  assign sig_unused = ^{addr_q.bytoff, (DWAYS != 2)};
`else
  assign lr_clear   = 1'b0;
  assign sig_unused = ^{addr_q.bytoff, addr_q.blkoff, valid_lr, link_register, (DWAYS != 2)};
`endif

  assign dbg_state = state_q;

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// Bench for dcache_snoop_responder: fixed vector table, reset/busy sequences, random snoops vs a reference model.
`timescale 1ns/1ps
module tb_dcache_snoop_responder;
  import cpu_types_pkg::*;

`ifdef DCACHE_SNOOP_LR_EN
  localparam bit LR_EN = 1'b1;
`else
  localparam bit LR_EN = 1'b0;
`endif

  localparam logic [25:0] TD = 26'h00002A5;
  localparam logic [25:0] TC = 26'h0012345;
  localparam logic [25:0] TB = 26'h0000077;

  // ---------------- clock / reset / DUT ----------------
  logic                    CLK = 1'b0;
  logic                    RST;
  logic                    snoop_req;
  logic [31:0]             snoop_addr;
  logic                    snoop_inv;
  logic                    snoop_dready;
  logic                    cache_busy;
  dcache_block [DSETS-1:0] way_0;
  dcache_block [DSETS-1:0] way_1;
  logic [31:0]             link_register;
  logic                    valid_lr;
  logic                    snoop_hit;
  logic                    snoop_dirty;
  logic [31:0]             snoop_data;
  logic                    snoop_dvalid;
  logic                    snoop_ack;
  logic                    upd_en;
  logic                    upd_way;
  logic [DIDX_W-1:0]       upd_idx;
  logic                    upd_valid;
  logic                    upd_dirty;
  logic                    lr_clear;
  snoop_state_t            dbg_state;
  logic [43:0]             out_vec;

  always #5 CLK = ~CLK;

  dcache_snoop_responder #(.DWAYS(2)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .snoop_req     (snoop_req),
    .snoop_addr    (snoop_addr),
    .snoop_inv     (snoop_inv),
    .snoop_dready  (snoop_dready),
    .cache_busy    (cache_busy),
    .way_0         (way_0),
    .way_1         (way_1),
    .link_register (link_register),
    .valid_lr      (valid_lr),
    .snoop_hit     (snoop_hit),
    .snoop_dirty   (snoop_dirty),
    .snoop_data    (snoop_data),
    .snoop_dvalid  (snoop_dvalid),
    .snoop_ack     (snoop_ack),
    .upd_en        (upd_en),
    .upd_way       (upd_way),
    .upd_idx       (upd_idx),
    .upd_valid     (upd_valid),
    .upd_dirty     (upd_dirty),
    .lr_clear      (lr_clear),
    .dbg_state     (dbg_state)
  );

  assign out_vec = {snoop_hit, snoop_dirty, snoop_data, snoop_dvalid, snoop_ack,
                    upd_en, upd_way, upd_idx, upd_valid, upd_dirty, lr_clear};

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          hit;
    bit          dirty;
    bit          way;
    bit          uvalid;
    logic [2:0]  idx;
    int          lat;
    logic [31:0] lo;
    logic [31:0] hi;
    int          lr_cnt;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          inv;
    int          s0;
    int          s1;
    bit          vlr;
    logic [31:0] link;
    exp_t        e;
  } vec_t;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] exp_q[$];
  vec_t        tbl[$];
  logic [25:0] tpool[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ad(input logic [25:0] t, input logic [2:0] i, input logic [2:0] lo);
    return {t, i, lo};
  endfunction

  function automatic exp_t mk(input bit hit, input bit dirty, input bit way, input bit uvalid,
                              input logic [2:0] idx, input int lat,
                              input logic [31:0] lo, input logic [31:0] hi, input int lr);
    exp_t e;
    e.hit = hit; e.dirty = dirty; e.way = way; e.uvalid = uvalid; e.idx = idx;
    e.lat = lat; e.lo = lo; e.hi = hi; e.lr_cnt = lr;
    return e;
  endfunction

  // Reference model: snoop outcome from the frame arrays and the protocol's latency rules.
  function automatic exp_t model(input logic [31:0] a, input bit inv, input int s0, input int s1);
    exp_t        e;
    logic [2:0]  idx;
    logic [25:0] t;
    bit          h0;
    bit          h1;
    dcache_block b;
    idx      = a[5:3];
    t        = a[31:6];
    h0       = way_0[idx].valid && (way_0[idx].tag == t);
    h1       = way_1[idx].valid && (way_1[idx].tag == t);
    b        = h0 ? way_0[idx] : way_1[idx];
    e.hit    = h0 || h1;
    e.way    = !h0 && h1;
    e.dirty  = e.hit && b.dirty;
    e.uvalid = !inv;
    e.idx    = idx;
    e.lat    = !e.hit ? 2 : (e.dirty ? 5 + s0 + s1 : 3);
    e.lo     = b.lower;
    e.hi     = b.upper;
    e.lr_cnt = (LR_EN && inv && valid_lr && (link_register[31:3] == a[31:3])) ? 1 : 0;
    return e;
  endfunction

  task automatic add_vec(input logic [31:0] a, input bit inv, input int s0, input int s1,
                         input bit vlr, input logic [31:0] link, input exp_t e);
    vec_t v;
    v.addr = a; v.inv = inv; v.s0 = s0; v.s1 = s1; v.vlr = vlr; v.link = link; v.e = e;
    tbl.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic setup_fixed();
    way_0 = '0;
    way_1 = '0;
    way_0[1] = '{valid: 1'b1, dirty: 1'b1, tag: TD, upper: 32'hBBBB_1111, lower: 32'hAAAA_0000};
    way_0[5] = '{valid: 1'b1, dirty: 1'b0, tag: 26'h1, upper: 32'h1111_0101, lower: 32'h2222_0202};
    way_1[5] = '{valid: 1'b1, dirty: 1'b0, tag: TC, upper: 32'h6666_0606, lower: 32'h5555_0505};
    way_0[3] = '{valid: 1'b1, dirty: 1'b0, tag: TB, upper: 32'h3333_0303, lower: 32'h4444_0404};
    way_1[3] = '{valid: 1'b1, dirty: 1'b1, tag: TB, upper: 32'h7777_0707, lower: 32'h8888_0808};
  endtask

  task automatic rand_arrays();
    for (int s = 0; s < DSETS; s++) begin
      way_0[s].valid = 1'($urandom_range(0, 1));
      way_0[s].dirty = 1'($urandom_range(0, 1));
      way_0[s].tag   = tpool[$urandom_range(0, 3)];
      way_0[s].upper = $urandom;
      way_0[s].lower = $urandom;
      way_1[s].valid = 1'($urandom_range(0, 1));
      way_1[s].dirty = 1'($urandom_range(0, 1));
      way_1[s].tag   = tpool[$urandom_range(0, 3)];
      way_1[s].upper = $urandom;
      way_1[s].lower = $urandom;
    end
  endtask

  // Starts in IDLE #1 after an edge; returns #1 after the edge following the ack.
  task automatic run_snoop(input logic [31:0] a, input bit inv, input int s0, input int s1,
                           input exp_t e, input string nm);
    int          n;
    int          stall_cnt;
    int          words;
    int          unstable;
    int          upd_cnt;
    int          lr_cnt;
    bit          done;
    logic        hit_l;
    logic        dirty_l;
    logic        hit_a;
    logic [5:0]  upd_vec;
    logic [31:0] held;
    n = 0; stall_cnt = 0; words = 0; unstable = 0; upd_cnt = 0; lr_cnt = 0; done = 0;
    hit_l = 0; dirty_l = 0; hit_a = 0; upd_vec = '0; held = '0;
    exp_q.delete();
    if (e.hit && e.dirty) begin
      exp_q.push_back(e.lo);
      exp_q.push_back(e.hi);
    end
    snoop_req = 1'b1; snoop_addr = a; snoop_inv = inv; cache_busy = 1'b0; snoop_dready = 1'b0;
    while (!done && n < 40) begin
      @(posedge CLK); #1;
      n++;
      if (n == 1) begin
        hit_l   = snoop_hit;
        dirty_l = snoop_dirty;
        // captured request must not follow later input changes
        snoop_addr = $urandom;
        snoop_inv  = 1'($urandom_range(0, 1));
        cache_busy = 1'($urandom_range(0, 1));
      end
      if (upd_en) begin
        upd_cnt++;
        upd_vec = {upd_way, upd_idx, upd_valid, upd_dirty};
      end
      if (lr_clear) lr_cnt++;
      if (snoop_dvalid) begin
        if (stall_cnt == 0) held = snoop_data;
        else if (snoop_data !== held) unstable++;
        if (stall_cnt >= ((words == 0) ? s0 : s1)) begin
          snoop_dready = 1'b1;
          if (exp_q.size() == 0) check({nm, "_extra_word"}, 64'(held), 64'hDEAD);
          else check($sformatf("%s_word%0d", nm, words), 64'(held), 64'(exp_q.pop_front()));
          words++;
          stall_cnt = 0;
        end else begin
          snoop_dready = 1'b0;
          stall_cnt++;
        end
      end else begin
        snoop_dready = 1'b0;
      end
      if (snoop_ack) begin
        done      = 1;
        hit_a     = snoop_hit;
        snoop_req = 1'b0;
      end
    end
    snoop_req = 1'b0; snoop_dready = 1'b0; cache_busy = 1'b0;
    check({nm, "_ack_seen"}, 64'(done), 64'd1);
    check({nm, "_ack_lat"}, 64'(n), 64'(e.lat));
    check({nm, "_hit_lookup"}, 64'(hit_l), 64'(e.hit));
    check({nm, "_hit_ack"}, 64'(hit_a), 64'(e.hit));
    check({nm, "_dirty"}, 64'(dirty_l), 64'(e.dirty));
    check({nm, "_upd_cnt"}, 64'(upd_cnt), 64'(e.hit ? 1 : 0));
    if (e.hit) check({nm, "_upd_fields"}, 64'(upd_vec), 64'({e.way, e.idx, e.uvalid, 1'b0}));
    check({nm, "_words"}, 64'(words), 64'((e.hit && e.dirty) ? 2 : 0));
    check({nm, "_stable"}, 64'(unstable), 64'd0);
    check({nm, "_lr_clear"}, 64'(lr_cnt), 64'(e.lr_cnt));
    @(posedge CLK); #1;
    check({nm, "_idle_outputs"}, 64'(out_vec), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int   uc;
    int   ac;
    exp_t e;
    tpool[0] = 26'h11; tpool[1] = 26'h22; tpool[2] = 26'h33; tpool[3] = TD;
    RST = 1'b1; snoop_req = 1'b0; snoop_addr = '0; snoop_inv = 1'b0; snoop_dready = 1'b0;
    cache_busy = 1'b0; link_register = '0; valid_lr = 1'b0; way_0 = '0; way_1 = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_outputs", 64'(out_vec), 64'd0);
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    RST = 1'b0;

    setup_fixed();
    add_vec(32'h0000_0010,      1'b0, 0, 0, 1'b0, 32'h0,          mk(0, 0, 0, 0, 3'd2, 2, 0, 0, 0));
    add_vec(ad(TC, 5, 3'b100),  1'b0, 0, 0, 1'b0, 32'h0,          mk(1, 0, 1, 1, 3'd5, 3, 0, 0, 0));
    add_vec(ad(TD, 1, 3'b000),  1'b1, 0, 3, 1'b0, 32'h0,
            mk(1, 1, 0, 0, 3'd1, 8, 32'hAAAA_0000, 32'hBBBB_1111, 0));
    add_vec(ad(TB, 3, 3'b011),  1'b0, 0, 0, 1'b0, 32'h0,          mk(1, 0, 0, 1, 3'd3, 3, 0, 0, 0));
    add_vec(ad(TC, 5, 3'b000),  1'b1, 0, 0, 1'b1, ad(TC, 5, 3'b111),
            mk(1, 0, 1, 0, 3'd5, 3, 0, 0, int'(LR_EN)));
    add_vec(32'h0000_1230,      1'b1, 0, 0, 1'b1, 32'h0000_1234,  mk(0, 0, 0, 0, 3'd6, 2, 0, 0, int'(LR_EN)));
    add_vec(ad(26'h3, 5, 3'b0), 1'b1, 0, 0, 1'b1, 32'h0000_1234,  mk(0, 0, 0, 0, 3'd5, 2, 0, 0, 0));
    add_vec(32'h0000_1230,      1'b0, 0, 0, 1'b1, 32'h0000_1234,  mk(0, 0, 0, 0, 3'd6, 2, 0, 0, 0));
    add_vec(ad(TD, 1, 3'b010),  1'b0, 2, 1, 1'b0, 32'h0,
            mk(1, 1, 0, 1, 3'd1, 8, 32'hAAAA_0000, 32'hBBBB_1111, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      valid_lr      = tbl[i].vlr;
      link_register = tbl[i].link;
      run_snoop(tbl[i].addr, tbl[i].inv, tbl[i].s0, tbl[i].s1, tbl[i].e, $sformatf("v%0d", i));
    end
    valid_lr = 1'b0; link_register = '0;

    // busy holds the FSM in IDLE
    cache_busy = 1'b1; snoop_req = 1'b1; snoop_addr = ad(TC, 5, 3'b000); snoop_inv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      check($sformatf("busy_state%0d", i), 64'(dbg_state), 64'(IDLE));
      check($sformatf("busy_outputs%0d", i), 64'(out_vec), 64'd0);
    end
    snoop_req = 1'b0; cache_busy = 1'b0;
    @(posedge CLK); #1;

    // reset while supplying the upper word
    snoop_req = 1'b1; snoop_addr = ad(TD, 1, 3'b000); snoop_inv = 1'b1; snoop_dready = 1'b0;
    @(posedge CLK); #1;
    snoop_dready = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("rst_pre_state", 64'(dbg_state), 64'(WORD1));
    check("rst_pre_data", 64'(snoop_data), 64'h0000_0000_BBBB_1111);
    RST = 1'b1; snoop_dready = 1'b0; snoop_req = 1'b0;
    @(posedge CLK); #1;
    check("rst_outputs", 64'(out_vec), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    RST = 1'b0;
    uc = 0; ac = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      if (upd_en) uc++;
      if (snoop_ack) ac++;
    end
    check("rst_no_upd", 64'(uc), 64'd0);
    check("rst_no_ack", 64'(ac), 64'd0);

    // randomized snoops against the model
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      bit          inv;
      int          s0;
      int          s1;
      if (k % 8 == 0) rand_arrays();
      a   = {tpool[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
      inv = 1'($urandom_range(0, 1));
      s0  = $urandom_range(0, 3);
      s1  = $urandom_range(0, 3);
      valid_lr      = 1'($urandom_range(0, 1));
      link_register = ($urandom_range(0, 1) == 1) ? {a[31:3], 3'($urandom_range(0, 7))} : $urandom;
      e = model(a, inv, s0, s1);
      run_snoop(a, inv, s0, s1, e, $sformatf("r%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    n_mis++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dcache_snoop_responder.md
DCACHE_SNOOP_RESPONDER -- requirements
Module: dcache_snoop_responder

Interface
REQ-001 Parameter: DWAYS, 2, number of ways examined; only value 2 is supported.
REQ-002 CLK  in  1  system clock; all state updates on rising edge.
REQ-003 RST  in  1  synchronous, active-high reset.
REQ-004 snoop_req  in  1  coherence controller snoop request; held high until snoop_ack.
REQ-005 snoop_addr  in  32  snooped address (dcachef_t layout: tag 26, idx 3, blkoff 1, bytoff 2).
REQ-006 snoop_inv  in  1  1 = invalidating snoop (BusRdX); 0 = sharing snoop (BusRd).
REQ-007 snoop_dready  in  1  requester accepts the current snoop_data word.
REQ-008 cache_busy  in  1  dcache controller owns the arrays this cycle; no new snoop may start.
REQ-009 way_0, way_1  in  8 x dcache_block each  current frame arrays (valid, dirty, tag, upper and lower words).
REQ-010 link_register  in  32; valid_lr  in  1  current LL/SC reservation.
REQ-011 snoop_hit  out  1  snooped block is present; valid from the LOOKUP cycle to ACK.
REQ-012 snoop_dirty  out  1  present block is dirty; data will follow.
REQ-013 snoop_data  out  32; snoop_dvalid  out  1  supplied word plus qualifier.
REQ-014 snoop_ack  out  1  one-cycle completion pulse.
REQ-015 upd_en  out  1; upd_way  out  1; upd_idx  out  3; upd_valid  out  1; upd_dirty  out  1  single-cycle frame-state write to the dcache.
REQ-016 lr_clear  out  1  one-cycle pulse; clears valid_lr.

Function
REQ-017 FSM states: IDLE, LOOKUP, WORD0, WORD1, UPDATE, ACK.
REQ-018 IDLE->LOOKUP when snoop_req & !cache_busy; snoop_addr and snoop_inv are captured in that cycle; later input changes are ignored until ACK.
REQ-019 LOOKUP: hit = valid & tag match in way_0 or way_1 at captured idx; way_0 wins if both match; upd_way records the hitting way.
REQ-020 LOOKUP->ACK on miss; ->WORD0 on dirty hit; ->UPDATE on clean hit.
REQ-021 WORD0 drives the lower word with snoop_dvalid=1 and advances to WORD1 only when snoop_dready=1; WORD1 drives the upper word and advances to UPDATE on snoop_dready=1; a stalled word holds stable.
REQ-022 UPDATE asserts upd_en for exactly one cycle with upd_idx = captured idx; snoop_inv=1 gives upd_valid=0, upd_dirty=0; snoop_inv=0 gives upd_valid=1, upd_dirty=0; then ->ACK.
REQ-023 ACK asserts snoop_ack for one cycle, then ->IDLE; the requester drops snoop_req in the ack cycle; a request still high in IDLE starts a new snoop.
REQ-024 Hit-to-ack latency: clean hit 3 cycles after capture, miss 2 cycles, dirty hit 5 cycles with zero dready stall.
REQ-025 cache_busy is sampled only in IDLE; it is ignored once a snoop has started.
REQ-026 All outputs not named active for the current state are 0.

Reset
REQ-027 RST=1 in any state forces IDLE, clears the captured address and the way, and drives all outputs to 0 on the next edge; an interrupted snoop issues no upd_en and no snoop_ack.

Configuration
REQ-028 DCACHE_SNOOP_LR_EN defined: in UPDATE or ACK of an invalidating snoop (hit or miss), assert lr_clear for one cycle if valid_lr and link_register[31:3] == captured addr[31:3]; emit it once per snoop.
REQ-029 DCACHE_SNOOP_LR_EN undefined: lr_clear is tied to 0, with no other change.

Structure
REQ-030 DTAG_W, DIDX_W, dcachef_t, dcache_block and the FSM state enum belong in cpu_types_pkg.
REQ-031 Single module; the tag-compare or hit-select logic is the only natural sub-module: dsnoop_tag_match.

Verification
REQ-032 Miss: way_0[2] and way_1[2] invalid, snoop addr 0x0000_0010 -> snoop_hit=0 and snoop_ack 2 cycles after capture, with no upd_en.
REQ-033 Clean hit, sharing snoop: way_1[5] valid and clean, tag matches -> upd_en with upd_way=1, upd_idx=5, upd_valid=1, then snoop_ack.
REQ-034 Dirty hit, invalidating snoop: way_0[1] holds 0xAAAA_0000 / 0xBBBB_1111 -> words 0xAAAA_0000 then 0xBBBB_1111, then upd_valid=0; hold snoop_dready low for 3 cycles on WORD1 and check the data stays stable.
REQ-035 LR clear: valid_lr=1, link_register=0x0000_1234, invalidating snoop to 0x0000_1230 -> one lr_clear pulse with the macro defined; no pulse when undefined.
REQ-036 Reset/busy: cache_busy=1 with snoop_req=1 -> FSM stays in IDLE; RST asserted in WORD1 -> all outputs 0 next cycle, with no upd_en or snoop_ack.
